// File: rtl/vga_salida_rgb_pipe.sv
// Registered VGA pixel output stage: delays sync/oe by the source read latency, scales and blanks colour,
// counts frames and flags oe-during-sync. Optional test-pattern generator under VGA_TEST_PATTERN_EN.
module vga_salida_rgb_pipe #(
   parameter int                CH_W     = 4,
   parameter int                IN_CH_W  = 4,
   parameter int                LAT      = 2,
   parameter logic [3*CH_W-1:0] BG_COLOR = '0,
   parameter int                BAR_W    = 80
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [3*IN_CH_W-1:0] i_pix_in,
   input  logic                 i_oe_in,
   input  logic                 i_hsync_in,
   input  logic                 i_vsync_in,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                 i_tp_sel,
`endif
   output logic [CH_W-1:0]      o_R,
   output logic [CH_W-1:0]      o_G,
   output logic [CH_W-1:0]      o_B,
   output logic                 o_hsync_out,
   output logic                 o_vsync_out,
   output logic                 o_oe_out,
   output logic [15:0]          o_frame_cnt,
   output logic                 o_sync_err
);

   // Timing delay line, element 0 is the live input, element LAT feeds the output stage. {oe,hs,vs}
   logic [2:0] w_tim [0:LAT];
   assign w_tim[0] = {i_oe_in, i_hsync_in, i_vsync_in};

   for (genvar gi = 1; gi <= LAT; gi++) begin : g_dly
      logic [2:0] r_stage;
      always_ff @(posedge i_clk) begin
         if (i_reset) r_stage <= 3'b011;
         else         r_stage <= w_tim[gi-1];
      end
      assign w_tim[gi] = r_stage;
   end

   logic w_oe_d, w_hs_d, w_vs_d;
   assign {w_oe_d, w_hs_d, w_vs_d} = w_tim[LAT];

   // One formula covers truncation, pass-through and MSB replication.
   function automatic logic [CH_W-1:0] f_scale(input logic [IN_CH_W-1:0] c);
      logic [CH_W-1:0] v;
      v = '0;
      for (int k = 0; k < CH_W; k++) v[CH_W-1-k] = c[IN_CH_W-1-(k % IN_CH_W)];
      return v;
   endfunction

`ifdef VGA_TEST_PATTERN_EN
   logic [10:0] r_col;
   logic [31:0] w_q;
   logic [2:0]  w_bar;

   always_ff @(posedge i_clk) begin
      if (i_reset)     r_col <= '0;
      else if (w_oe_d) r_col <= r_col + 11'd1;
      else             r_col <= '0;
   end

   assign w_q   = {21'd0, r_col} / BAR_W;
   assign w_bar = (w_q > 32'd7) ? 3'd7 : w_q[2:0];
`endif

   logic [3*CH_W-1:0] w_pix, w_rgb;

   always_comb begin
      w_pix = {f_scale(i_pix_in[3*IN_CH_W-1 -: IN_CH_W]),
               f_scale(i_pix_in[2*IN_CH_W-1 -: IN_CH_W]),
               f_scale(i_pix_in[IN_CH_W-1:0])};
`ifdef VGA_TEST_PATTERN_EN
      if (i_tp_sel) w_pix = {{CH_W{w_bar[2]}}, {CH_W{w_bar[1]}}, {CH_W{w_bar[0]}}};
`endif
      w_rgb = (w_oe_d && w_hs_d && w_vs_d) ? w_pix : BG_COLOR;
   end

   logic [3*CH_W-1:0] r_rgb;
   logic              r_hs, r_vs, r_oe, r_err;
   logic [15:0]       r_frame;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rgb   <= '0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_oe    <= 1'b0;
         r_frame <= '0;
         r_err   <= 1'b0;
      end else begin
         r_rgb <= w_rgb;
         r_hs  <= w_hs_d;
         r_vs  <= w_vs_d;
         r_oe  <= w_oe_d;
         // r_vs holds the previous vs_d, so this is its falling edge
         if (r_vs && !w_vs_d) r_frame <= r_frame + 16'd1;
         if (w_oe_d && (!w_hs_d || !w_vs_d)) r_err <= 1'b1;
      end
   end

   assign o_R         = r_rgb[3*CH_W-1 -: CH_W];
   assign o_G         = r_rgb[2*CH_W-1 -: CH_W];
   assign o_B         = r_rgb[CH_W-1:0];
   assign o_hsync_out = r_hs;
   assign o_vsync_out = r_vs;
   assign o_oe_out    = r_oe;
   assign o_frame_cnt = r_frame;
   assign o_sync_err  = r_err;

endmodule
